// File: rtl/regfile_rename_mp.sv
// Architectural register file with per-register pending-producer tags for a rename stage.
// Latency: reads are registered (1 cycle) with same-cycle commit/rename bypass.
// Backpressure: none; every port is accepted each cycle, flush overrides renames.
module regfile_rename_mp #(
  parameter int XLEN     = 32,
  parameter int ROB_BITS = 4,
  parameter int NRP      = 4,
  parameter int NCP      = 2,
  parameter int NDP      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCP-1:0]             cm_wen,
  input  logic [5*NCP-1:0]           cm_idx,
  input  logic [(ROB_BITS+1)*NCP-1:0] cm_tag,
  input  logic [XLEN*NCP-1:0]        cm_data,
  input  logic [NDP-1:0]             dc_wen,
  input  logic [5*NDP-1:0]           dc_idx,
  input  logic [(ROB_BITS+1)*NDP-1:0] dc_tag,
  input  logic                       flush,
  input  logic [5*NRP-1:0]           rd_idx,
  output logic [XLEN*NRP-1:0]        rd_data,
  output logic [(ROB_BITS+1)*NRP-1:0] rd_tag
);

  localparam int TW = ROB_BITS + 1;

  logic [XLEN-1:0] regs   [32];
  logic [TW-1:0]   tags   [32];
  logic [XLEN-1:0] regs_n [32];
  logic [TW-1:0]   tags_n [32];

  logic [NCP-1:0]      cm_vld;
  logic [NDP-1:0]      dc_vld;
  logic [XLEN*NRP-1:0] rd_data_n;
  logic [TW*NRP-1:0]   rd_tag_n;

  // Port qualification: index 0 and tag 0 are never real targets; flush kills renames.
  always_comb begin
    cm_vld = '0;
    dc_vld = '0;
    for (int k = 0; k < NCP; k++) begin
      cm_vld[k] = cm_wen[k] && (cm_idx[5*k +: 5] != 5'd0) && (cm_tag[TW*k +: TW] != '0);
    end
    for (int k = 0; k < NDP; k++) begin
      dc_vld[k] = dc_wen[k] && (dc_idx[5*k +: 5] != 5'd0) && (dc_tag[TW*k +: TW] != '0) && !flush;
    end
  end

  // Next architectural state: commits first, then renames override clears, flush wipes all tags.
  always_comb begin
    regs_n = regs;
    tags_n = tags;
    for (int k = 0; k < NCP; k++) begin
      if (cm_vld[k]) begin
        regs_n[cm_idx[5*k +: 5]] = cm_data[XLEN*k +: XLEN];
        // Only the producer the tag still points at may clear it; a newer rename keeps its tag.
        if (tags[cm_idx[5*k +: 5]] == cm_tag[TW*k +: TW]) begin
          tags_n[cm_idx[5*k +: 5]] = '0;
        end
      end
    end
    for (int k = 0; k < NDP; k++) begin
      if (dc_vld[k]) begin
        tags_n[dc_idx[5*k +: 5]] = dc_tag[TW*k +: TW];
      end
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) begin
        tags_n[i] = '0;
      end
    end
  end

  // Read capture with bypass so a read sees the same-cycle commit data and tag outcome.
  always_comb begin
    rd_data_n = '0;
    rd_tag_n  = '0;
    for (int p = 0; p < NRP; p++) begin
      rd_data_n[XLEN*p +: XLEN] = regs[rd_idx[5*p +: 5]];
      rd_tag_n[TW*p +: TW]      = tags[rd_idx[5*p +: 5]];
      for (int k = 0; k < NCP; k++) begin
        if (cm_vld[k] && (cm_idx[5*k +: 5] == rd_idx[5*p +: 5])) begin
          rd_data_n[XLEN*p +: XLEN] = cm_data[XLEN*k +: XLEN];
          if (tags[rd_idx[5*p +: 5]] == cm_tag[TW*k +: TW]) begin
            rd_tag_n[TW*p +: TW] = '0;
          end
        end
      end
      for (int k = 0; k < NDP; k++) begin
        if (dc_vld[k] && (dc_idx[5*k +: 5] == rd_idx[5*p +: 5])) begin
          rd_tag_n[TW*p +: TW] = dc_tag[TW*k +: TW];
        end
      end
      if (flush) begin
        rd_tag_n[TW*p +: TW] = '0;
      end
    end
  end

  // State and read-port registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
        tags[i] <= '0;
      end
      rd_data <= '0;
      rd_tag  <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= regs_n[i];
        tags[i] <= tags_n[i];
      end
      rd_data <= rd_data_n;
      rd_tag  <= rd_tag_n;
    end
  end

endmodule

// File: tb/tb_regfile_rename_mp.sv
module tb_regfile_rename_mp;

  localparam int XLEN = 32;
  localparam int TW   = 5;
  localparam int NRP  = 4;
  localparam int NCP  = 2;
  localparam int NDP  = 2;

  logic                 clk;
  logic                 rst;
  logic [NCP-1:0]       cm_wen;
  logic [5*NCP-1:0]     cm_idx;
  logic [TW*NCP-1:0]    cm_tag;
  logic [XLEN*NCP-1:0]  cm_data;
  logic [NDP-1:0]       dc_wen;
  logic [5*NDP-1:0]     dc_idx;
  logic [TW*NDP-1:0]    dc_tag;
  logic                 flush;
  logic [5*NRP-1:0]     rd_idx;
  logic [XLEN*NRP-1:0]  rd_data;
  logic [TW*NRP-1:0]    rd_tag;

  int total;
  int bad;

  regfile_rename_mp #(.XLEN(XLEN), .ROB_BITS(4), .NRP(NRP), .NCP(NCP), .NDP(NDP)) dut (
    .clk(clk), .rst(rst),
    .cm_wen(cm_wen), .cm_idx(cm_idx), .cm_tag(cm_tag), .cm_data(cm_data),
    .dc_wen(dc_wen), .dc_idx(dc_idx), .dc_tag(dc_tag),
    .flush(flush), .rd_idx(rd_idx), .rd_data(rd_data), .rd_tag(rd_tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [XLEN-1:0] dat_of(int p);
    return rd_data[XLEN*p +: XLEN];
  endfunction

  function automatic logic [TW-1:0] tag_of(int p);
    return rd_tag[TW*p +: TW];
  endfunction

  task automatic idle();
    cm_wen = '0; cm_idx = '0; cm_tag = '0; cm_data = '0;
    dc_wen = '0; dc_idx = '0; dc_tag = '0; flush = 1'b0;
  endtask

  task automatic commit(int p, logic [4:0] idx, logic [TW-1:0] tag, logic [XLEN-1:0] data);
    cm_wen[p] = 1'b1;
    cm_idx[5*p +: 5] = idx;
    cm_tag[TW*p +: TW] = tag;
    cm_data[XLEN*p +: XLEN] = data;
  endtask

  task automatic rename(int p, logic [4:0] idx, logic [TW-1:0] tag);
    dc_wen[p] = 1'b1;
    dc_idx[5*p +: 5] = idx;
    dc_tag[TW*p +: TW] = tag;
  endtask

  task automatic rd(int p, logic [4:0] idx);
    rd_idx[5*p +: 5] = idx;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", rd_data); end
    total++; if (rd_tag !== '0) begin bad++; $display("FAIL reset_tag got=%h exp=0", rd_tag); end
    tick(); tick();
    #2 rst = 1'b0;
    rd_idx = '0;
    tick();
    total++; if (rd_data !== '0 || rd_tag !== '0) begin bad++; $display("FAIL post_reset got=%h/%h exp=0/0", rd_data, rd_tag); end
  endtask

  task automatic test_rename_read();
    idle(); rename(0, 5'd5, 5'd3); rd(0, 5'd5);
    tick();
    total++; if (tag_of(0) !== 5'd3) begin bad++; $display("FAIL rename_bypass_tag got=%0d exp=3", tag_of(0)); end
    idle(); rd(1, 5'd5);
    tick();
    total++; if (tag_of(1) !== 5'd3) begin bad++; $display("FAIL rename_read_tag got=%0d exp=3", tag_of(1)); end
    total++; if (dat_of(1) !== 32'h0) begin bad++; $display("FAIL rename_read_data got=%h exp=0", dat_of(1)); end
  endtask

  task automatic test_commit();
    idle(); commit(0, 5'd5, 5'd3, 32'hAB); rd(0, 5'd5);
    tick();
    total++; if (dat_of(0) !== 32'hAB) begin bad++; $display("FAIL commit_fwd_data got=%h exp=ab", dat_of(0)); end
    total++; if (tag_of(0) !== 5'd0) begin bad++; $display("FAIL commit_fwd_tag got=%0d exp=0", tag_of(0)); end
    idle();
    tick();
    total++; if (dat_of(0) !== 32'hAB || tag_of(0) !== 5'd0) begin bad++; $display("FAIL commit_state got=%h/%0d exp=ab/0", dat_of(0), tag_of(0)); end
  endtask

  task automatic test_stale_commit();
    idle(); rename(1, 5'd5, 5'd7); rd(0, 5'd5);
    tick();
    idle(); commit(0, 5'd5, 5'd3, 32'h55);
    tick();
    total++; if (dat_of(0) !== 32'h55 || tag_of(0) !== 5'd7) begin bad++; $display("FAIL stale_fwd got=%h/%0d exp=55/7", dat_of(0), tag_of(0)); end
    idle();
    tick();
    total++; if (dat_of(0) !== 32'h55 || tag_of(0) !== 5'd7) begin bad++; $display("FAIL stale_state got=%h/%0d exp=55/7", dat_of(0), tag_of(0)); end
  endtask

  task automatic test_multi_port();
    idle(); rename(0, 5'd9, 5'd2); rename(1, 5'd9, 5'd4); rd(2, 5'd9);
    tick();
    total++; if (tag_of(2) !== 5'd4) begin bad++; $display("FAIL dual_rename_bypass got=%0d exp=4", tag_of(2)); end
    idle();
    tick();
    total++; if (tag_of(2) !== 5'd4) begin bad++; $display("FAIL dual_rename_state got=%0d exp=4", tag_of(2)); end
    idle(); commit(0, 5'd9, 5'd2, 32'd1); commit(1, 5'd9, 5'd4, 32'd2);
    tick();
    total++; if (dat_of(2) !== 32'd2 || tag_of(2) !== 5'd0) begin bad++; $display("FAIL dual_commit_fwd got=%h/%0d exp=2/0", dat_of(2), tag_of(2)); end
    idle();
    tick();
    total++; if (dat_of(2) !== 32'd2 || tag_of(2) !== 5'd0) begin bad++; $display("FAIL dual_commit_state got=%h/%0d exp=2/0", dat_of(2), tag_of(2)); end
  endtask

  task automatic test_flush();
    idle(); rename(0, 5'd7, 5'd5); rename(1, 5'd4, 5'd2);
    tick();
    idle(); flush = 1'b1; rename(0, 5'd3, 5'd6); commit(0, 5'd4, 5'd1, 32'd9);
    rd(0, 5'd3); rd(1, 5'd4); rd(2, 5'd7); rd(3, 5'd5);
    tick();
    total++; if (rd_tag !== '0) begin bad++; $display("FAIL flush_tags_fwd got=%h exp=0", rd_tag); end
    total++; if (dat_of(1) !== 32'd9 || dat_of(3) !== 32'h55 || dat_of(0) !== 32'd0) begin bad++; $display("FAIL flush_data_fwd got=%h exp=00000055_00000000_00000009_00000000", rd_data); end
    idle();
    tick();
    total++; if (rd_tag !== '0) begin bad++; $display("FAIL flush_tags_state got=%h exp=0", rd_tag); end
    total++; if (dat_of(1) !== 32'd9) begin bad++; $display("FAIL flush_data_state got=%h exp=9", dat_of(1)); end
  endtask

  task automatic test_rename_over_commit();
    idle(); rename(0, 5'd10, 5'd8); rd(0, 5'd10);
    tick();
    idle(); commit(0, 5'd10, 5'd8, 32'h77); rename(1, 5'd10, 5'd9);
    tick();
    total++; if (dat_of(0) !== 32'h77 || tag_of(0) !== 5'd9) begin bad++; $display("FAIL ren_over_cm_fwd got=%h/%0d exp=77/9", dat_of(0), tag_of(0)); end
    idle();
    tick();
    total++; if (tag_of(0) !== 5'd9) begin bad++; $display("FAIL ren_over_cm_state got=%0d exp=9", tag_of(0)); end
  endtask

  task automatic test_r0();
    idle(); commit(0, 5'd0, 5'd1, 32'hFF); commit(1, 5'd0, 5'd2, 32'hEE); rename(0, 5'd0, 5'd3);
    rd(0, 5'd0);
    tick();
    total++; if (dat_of(0) !== 32'd0 || tag_of(0) !== 5'd0) begin bad++; $display("FAIL r0_fwd got=%h/%0d exp=0/0", dat_of(0), tag_of(0)); end
    idle();
    tick();
    total++; if (dat_of(0) !== 32'd0 || tag_of(0) !== 5'd0) begin bad++; $display("FAIL r0_state got=%h/%0d exp=0/0", dat_of(0), tag_of(0)); end
  endtask

  task automatic test_reset_mid();
    idle(); commit(0, 5'd12, 5'd1, 32'h33); rename(0, 5'd11, 5'd12);
    rd(0, 5'd12); rd(1, 5'd11);
    tick();
    total++; if (dat_of(0) !== 32'h33 || tag_of(1) !== 5'd12) begin bad++; $display("FAIL pre_rst got=%h/%0d exp=33/12", dat_of(0), tag_of(1)); end
    idle(); rename(1, 5'd11, 5'd13);
    #2 rst = 1'b1;
    #1;
    total++; if (rd_data !== '0 || rd_tag !== '0) begin bad++; $display("FAIL async_rst got=%h/%h exp=0/0", rd_data, rd_tag); end
    tick();
    #2 rst = 1'b0;
    idle();
    tick();
    total++; if (dat_of(0) !== 32'd0 || tag_of(1) !== 5'd0) begin bad++; $display("FAIL after_rst got=%h/%0d exp=0/0", dat_of(0), tag_of(1)); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    rd_idx = '0;
    idle();
    test_reset();
    test_rename_read();
    test_commit();
    test_stale_commit();
    test_multi_port();
    test_flush();
    test_rename_over_commit();
    test_r0();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
